// File: rtl/csr_commit_unit_pkg.sv
// Shared definitions for the commit-side CSR producer and the CSR file.
// Contents:
//   - exception code / subcode constants
//   - bit positions inside the retiring instruction's exception flag vector
//   - CSR operation encodings
//   - packed exception bus layout (field order is shared with the CSR file)
//   - commit FSM state type and the CSRXCHG merge helper
package csr_commit_unit_pkg;

  localparam int CSR_BUS_WD = 82;

  // Exception codes and subcodes
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
  localparam logic [5:0] ECODE_IPE = 6'h0E;

  localparam logic [8:0] ESUB_NONE = 9'd0;
  localparam logic [8:0] ESUB_ADEM = 9'd1;

  // Bit positions in in_excp_vec; bit 7 is reserved and never decoded
  localparam int EXC_ADEF = 0;
  localparam int EXC_INE  = 1;
  localparam int EXC_IPE  = 2;
  localparam int EXC_SYS  = 3;
  localparam int EXC_BRK  = 4;
  localparam int EXC_ALE  = 5;
  localparam int EXC_ADEM = 6;
  localparam int EXC_RSVD = 7;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RD   = 2'd1,
    CSR_OP_WR   = 2'd2,
    CSR_OP_XCHG = 2'd3
  } csr_op_e;

  // Source of the bad virtual address reported with an exception
  typedef enum logic [1:0] {
    BADV_NONE = 2'd0,
    BADV_PC   = 2'd1,
    BADV_ADDR = 2'd2
  } badv_sel_e;

  // Exception bus, MSB first; total width equals CSR_BUS_WD
  typedef struct packed {
    logic        is_etrn;
    logic        in_excp;
    logic [5:0]  ecode;
    logic [8:0]  subecode;
    logic [31:0] era;
    logic        use_badv;
    logic [31:0] badv;
  } csr_bus_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2
  } commit_state_e;

  // CSRXCHG: masked bits come from the new value, the rest keep the old value
  function automatic logic [31:0] xchg_merge(input logic [31:0] new_val,
                                             input logic [31:0] old_val,
                                             input logic [31:0] mask);
    return (new_val & mask) | (old_val & ~mask);
  endfunction

endpackage

// File: rtl/csr_commit_unit_excp_prio_enc.sv
// Combinational exception priority encoder.
// Ports:
//   intrpt    in  1 : pending interrupt, outranks every instruction exception
//   excp_vec  in  7 : instruction exception flags (reserved bit excluded)
//   hit       out 1 : some exception or interrupt is taken
//   ecode     out 6 : exception code of the winner
//   subecode  out 9 : exception subcode of the winner
//   use_badv  out 1 : winner reports a bad virtual address
//   badv_sel  out 2 : which address is reported as badv
module excp_prio_enc
  import csr_commit_unit_pkg::*;
(
  input  logic       intrpt,
  input  logic [6:0] excp_vec,
  output logic       hit,
  output logic [5:0] ecode,
  output logic [8:0] subecode,
  output logic       use_badv,
  output badv_sel_e  badv_sel
);

  // NOTE: every output gets a default before the if-chain, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    hit      = 1'b1;
    ecode    = ECODE_INT;
    subecode = ESUB_NONE;
    badv_sel = BADV_NONE;
    if (intrpt) begin
      ecode = ECODE_INT;
    end else if (excp_vec[EXC_ADEF]) begin
      ecode    = ECODE_ADE;
      badv_sel = BADV_PC;
    end else if (excp_vec[EXC_INE]) begin
      ecode = ECODE_INE;
    end else if (excp_vec[EXC_IPE]) begin
      ecode = ECODE_IPE;
    end else if (excp_vec[EXC_SYS]) begin
      ecode = ECODE_SYS;
    end else if (excp_vec[EXC_BRK]) begin
      ecode = ECODE_BRK;
    end else if (excp_vec[EXC_ALE]) begin
      ecode    = ECODE_ALE;
      badv_sel = BADV_ADDR;
    end else if (excp_vec[EXC_ADEM]) begin
      ecode    = ECODE_ADE;
      subecode = ESUB_ADEM;
      badv_sel = BADV_ADDR;
    end else begin
      hit = 1'b0;
    end
  end

  assign use_badv = (badv_sel != BADV_NONE);

endmodule

// File: rtl/csr_commit_unit.sv
// Commit-side producer for the CSR file. Accepts one retiring instruction per
// handshake, resolves interrupt / exception / ERTN, performs CSRRD, CSRWR and
// CSRXCHG, and holds the pipeline off while the post-redirect flush drains.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : retiring instruction handshake
//   in_pc, in_excp_vec,
//   in_badv, in_is_ertn      : instruction PC, exception flags, data address, ERTN
//   in_csr_op, in_csr_num,
//   in_rd_val, in_rj_mask    : CSR operation, number, write data, XCHG mask
//   have_intrpt              : pending enabled interrupt, sampled at accept
//   csr_raddr / csr_rdata    : combinational CSR read port
//   csr_bus                  : registered exception bus (one-cycle pulse)
//   csr_wen/waddr/wdata      : registered CSR write request
//   rd_we / rd_wdata         : registered old-CSR-value write-back
//   flush                    : registered redirect pulse
module csr_commit_unit
  import csr_commit_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CSR_BUS_WD   = csr_commit_unit_pkg::CSR_BUS_WD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [7:0]            in_excp_vec,
  input  logic [31:0]           in_badv,
  input  logic                  in_is_ertn,
  input  logic [1:0]            in_csr_op,
  input  logic [13:0]           in_csr_num,
  input  logic [31:0]           in_rd_val,
  input  logic [31:0]           in_rj_mask,
  input  logic                  have_intrpt,
  output logic [13:0]           csr_raddr,
  input  logic [31:0]           csr_rdata,
  output logic [CSR_BUS_WD-1:0] csr_bus,
  output logic                  csr_wen,
  output logic [13:0]           csr_waddr,
  output logic [31:0]           csr_wdata,
  output logic                  rd_we,
  output logic [31:0]           rd_wdata,
  output logic                  flush
);

  localparam logic [3:0] FLUSH_CNT_INIT = 4'(FLUSH_CYCLES - 1);

  commit_state_e state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic          accept;

  // Reserved exception flag is deliberately ignored
  logic unused_rsvd;
  assign unused_rsvd = in_excp_vec[EXC_RSVD];

  // ISSUE only keeps accepting when the issued result did not redirect
  assign in_ready  = (state == ST_IDLE) || ((state == ST_ISSUE) && !flush);
  assign accept    = in_valid && in_ready;
  assign csr_raddr = in_csr_num;

  // ---------------------------------------------------------------------
  // Exception resolution
  // ---------------------------------------------------------------------
  logic       excp_hit;
  logic [5:0] excp_ecode;
  logic [8:0] excp_sub;
  logic       excp_use_badv;
  badv_sel_e  excp_badv_sel;

  excp_prio_enc u_prio (
    .intrpt   (have_intrpt),
    .excp_vec (in_excp_vec[6:0]),
    .hit      (excp_hit),
    .ecode    (excp_ecode),
    .subecode (excp_sub),
    .use_badv (excp_use_badv),
    .badv_sel (excp_badv_sel)
  );

  // A write issued last cycle is not yet visible on csr_rdata, so forward it
  logic [31:0] old_val;
  assign old_val = (csr_wen && (csr_waddr == in_csr_num)) ? csr_wdata : csr_rdata;

  csr_op_e     op;
  csr_bus_t    bus_d, bus_q;
  logic        wen_d, rd_we_d, flush_d;
  logic [31:0] wdata_d;

  assign op = csr_op_e'(in_csr_op);

  always_comb begin
    bus_d   = '0;
    wen_d   = 1'b0;
    rd_we_d = 1'b0;
    flush_d = 1'b0;
    wdata_d = in_rd_val;
    if (excp_hit) begin
      // Interrupt or exception: CSR side effects are suppressed
      bus_d.in_excp  = 1'b1;
      bus_d.ecode    = excp_ecode;
      bus_d.subecode = excp_sub;
      bus_d.era      = in_pc;
      bus_d.use_badv = excp_use_badv;
      unique case (excp_badv_sel)
        BADV_PC:   bus_d.badv = in_pc;
        BADV_ADDR: bus_d.badv = in_badv;
        default:   bus_d.badv = '0;
      endcase
      flush_d = 1'b1;
    end else if (in_is_ertn) begin
      bus_d.is_etrn = 1'b1;
      flush_d       = 1'b1;
    end else begin
      unique case (op)
        CSR_OP_RD: rd_we_d = 1'b1;
        CSR_OP_WR: begin
          wen_d   = 1'b1;
          rd_we_d = 1'b1;
        end
        CSR_OP_XCHG: begin
          wen_d   = 1'b1;
          rd_we_d = 1'b1;
          wdata_d = xchg_merge(in_rd_val, old_val, in_rj_mask);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Commit FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (flush) begin
          state_next = ST_FLUSH;
          cnt_next   = FLUSH_CNT_INIT;
        end else if (accept) begin
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt == 4'd0) state_next = ST_IDLE;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Pulse outputs last exactly one cycle; address/data hold until next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q     <= '0;
      csr_wen   <= 1'b0;
      csr_waddr <= '0;
      csr_wdata <= '0;
      rd_we     <= 1'b0;
      rd_wdata  <= '0;
      flush     <= 1'b0;
    end else if (accept) begin
      bus_q     <= bus_d;
      csr_wen   <= wen_d;
      csr_waddr <= in_csr_num;
      csr_wdata <= wdata_d;
      rd_we     <= rd_we_d;
      rd_wdata  <= old_val;
      flush     <= flush_d;
    end else begin
      bus_q   <= '0;
      csr_wen <= 1'b0;
      rd_we   <= 1'b0;
      flush   <= 1'b0;
    end
  end

  assign csr_bus = CSR_BUS_WD'(bus_q);

endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed self-checking bench for csr_commit_unit. Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_csr_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [7:0]  in_excp_vec;
  logic [31:0] in_badv;
  logic        in_is_ertn;
  logic [1:0]  in_csr_op;
  logic [13:0] in_csr_num;
  logic [31:0] in_rd_val;
  logic [31:0] in_rj_mask;
  logic        have_intrpt;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [81:0] csr_bus;
  logic        csr_wen;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        rd_we;
  logic [31:0] rd_wdata;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csr_commit_unit #(.FLUSH_CYCLES(2), .CSR_BUS_WD(82)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_excp_vec (in_excp_vec),
    .in_badv     (in_badv),
    .in_is_ertn  (in_is_ertn),
    .in_csr_op   (in_csr_op),
    .in_csr_num  (in_csr_num),
    .in_rd_val   (in_rd_val),
    .in_rj_mask  (in_rj_mask),
    .have_intrpt (have_intrpt),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .csr_bus     (csr_bus),
    .csr_wen     (csr_wen),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .rd_we       (rd_we),
    .rd_wdata    (rd_wdata),
    .flush       (flush)
  );

  function automatic logic [81:0] mk_bus(input logic et, input logic ex,
                                         input logic [5:0] ec, input logic [8:0] sub,
                                         input logic [31:0] era, input logic ub,
                                         input logic [31:0] badv);
    return {et, ex, ec, sub, era, ub, badv};
  endfunction

  task automatic check(input string tag, input logic [81:0] obs, input logic [81:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_excp_vec = '0;
    in_is_ertn  = 1'b0;
    in_csr_op   = 2'd0;
    have_intrpt = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // After a redirect's ISSUE cycle: two blocked cycles, then ready again
  task automatic wait_redirect(input string tag);
    cyc();
    check({tag, "_flush_pulse_off"}, flush, 1'b0);
    check({tag, "_blocked1"}, in_ready, 1'b0);
    cyc();
    check({tag, "_blocked2"}, in_ready, 1'b0);
    cyc();
    check({tag, "_ready_again"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    in_pc      = '0;
    in_badv    = '0;
    in_csr_num = '0;
    in_rd_val  = '0;
    in_rj_mask = '0;
    csr_rdata  = '0;
    idle_inputs();
    cyc();
    cyc();

    // Reset state
    check("rst_bus",      csr_bus,   '0);
    check("rst_wen",      csr_wen,   1'b0);
    check("rst_waddr",    csr_waddr, 14'h0);
    check("rst_wdata",    csr_wdata, 32'h0);
    check("rst_rd_we",    rd_we,     1'b0);
    check("rst_rd_wdata", rd_wdata,  32'h0);
    check("rst_flush",    flush,     1'b0);
    check("rst_ready",    in_ready,  1'b1);
    rst = 1'b0;
    cyc();

    // SYS exception
    in_valid = 1'b1; in_excp_vec = 8'h08; in_pc = 32'h1C00_0100;
    check("sys_accept_ready", in_ready, 1'b1);
    cyc(); idle_inputs();
    check("sys_bus",   csr_bus, mk_bus(1'b0, 1'b1, 6'h0B, 9'd0, 32'h1C00_0100, 1'b0, 32'h0));
    check("sys_flush", flush,   1'b1);
    check("sys_wen",   csr_wen, 1'b0);
    check("sys_rd_we", rd_we,   1'b0);
    check("sys_issue_ready", in_ready, 1'b0);
    wait_redirect("sys");
    check("sys_bus_cleared", csr_bus, '0);

    // ALE beats ADEM
    in_valid = 1'b1; in_excp_vec = 8'h60; in_pc = 32'h1C00_0200; in_badv = 32'h3;
    cyc(); idle_inputs();
    check("ale_bus", csr_bus, mk_bus(1'b0, 1'b1, 6'h09, 9'd0, 32'h1C00_0200, 1'b1, 32'h3));
    wait_redirect("ale");

    // ADEF reports the PC as badv
    in_valid = 1'b1; in_excp_vec = 8'h01; in_pc = 32'h1C00_0400; in_badv = 32'hDEAD;
    cyc(); idle_inputs();
    check("adef_bus", csr_bus, mk_bus(1'b0, 1'b1, 6'h08, 9'd0, 32'h1C00_0400, 1'b1, 32'h1C00_0400));
    wait_redirect("adef");

    // ADEM alone: ecode 0x08 subcode 1
    in_valid = 1'b1; in_excp_vec = 8'h40; in_pc = 32'h1C00_0500; in_badv = 32'h8000_0010;
    cyc(); idle_inputs();
    check("adem_bus", csr_bus, mk_bus(1'b0, 1'b1, 6'h08, 9'd1, 32'h1C00_0500, 1'b1, 32'h8000_0010));
    wait_redirect("adem");

    // INE outranks SYS, no badv
    in_valid = 1'b1; in_excp_vec = 8'h0A; in_pc = 32'h1C00_0540; in_badv = 32'h1234;
    cyc(); idle_inputs();
    check("ine_bus", csr_bus, mk_bus(1'b0, 1'b1, 6'h0D, 9'd0, 32'h1C00_0540, 1'b0, 32'h0));
    wait_redirect("ine");

    // XCHG
    in_valid = 1'b1; in_csr_op = 2'd3; in_csr_num = 14'h030;
    csr_rdata = 32'hFFFF_0000; in_rd_val = 32'h1234_5678; in_rj_mask = 32'h0000_FFFF;
    check("xchg_raddr", csr_raddr, 14'h030);
    cyc(); idle_inputs();
    check("xchg_wen",      csr_wen,   1'b1);
    check("xchg_waddr",    csr_waddr, 14'h030);
    check("xchg_wdata",    csr_wdata, 32'hFFFF_5678);
    check("xchg_rd_we",    rd_we,     1'b1);
    check("xchg_rd_wdata", rd_wdata,  32'hFFFF_0000);
    check("xchg_flush",    flush,     1'b0);
    check("xchg_bus",      csr_bus,   '0);
    check("xchg_ready",    in_ready,  1'b1);
    cyc();
    check("xchg_wen_pulse", csr_wen, 1'b0);

    // Back-to-back WR SAVE0 then RD SAVE0 with stale csr_rdata
    in_valid = 1'b1; in_csr_op = 2'd2; in_csr_num = 14'h030;
    in_rd_val = 32'hA; csr_rdata = 32'h0;
    cyc();
    check("wr_wen",      csr_wen,   1'b1);
    check("wr_wdata",    csr_wdata, 32'hA);
    check("wr_rd_wdata", rd_wdata,  32'h0);
    check("wr_b2b_ready", in_ready, 1'b1);
    in_csr_op = 2'd1; in_rd_val = 32'h0;
    cyc(); idle_inputs();
    check("rd_fwd_rd_we",    rd_we,    1'b1);
    check("rd_fwd_rd_wdata", rd_wdata, 32'hA);
    check("rd_fwd_wen",      csr_wen,  1'b0);
    cyc();
    check("rd_we_pulse", rd_we, 1'b0);

    // Reserved flag only: plain RD goes through
    in_valid = 1'b1; in_excp_vec = 8'h80; in_csr_op = 2'd1; in_csr_num = 14'h005;
    csr_rdata = 32'h77;
    cyc(); idle_inputs();
    check("rsvd_bus",      csr_bus,  '0);
    check("rsvd_flush",    flush,    1'b0);
    check("rsvd_rd_we",    rd_we,    1'b1);
    check("rsvd_rd_wdata", rd_wdata, 32'h77);
    check("rsvd_wen",      csr_wen,  1'b0);
    cyc();

    // Interrupt with a WR (and a SYS flag) pending
    in_valid = 1'b1; have_intrpt = 1'b1; in_excp_vec = 8'h08; in_csr_op = 2'd2;
    in_csr_num = 14'h030; in_rd_val = 32'h55; in_pc = 32'h1C00_0600;
    cyc(); idle_inputs();
    check("int_bus",   csr_bus, mk_bus(1'b0, 1'b1, 6'h00, 9'd0, 32'h1C00_0600, 1'b0, 32'h0));
    check("int_wen",   csr_wen, 1'b0);
    check("int_rd_we", rd_we,   1'b0);
    check("int_flush", flush,   1'b1);
    wait_redirect("int");

    // ERTN with an ignored CSR op, then reset in FLUSH
    in_valid = 1'b1; in_is_ertn = 1'b1; in_csr_op = 2'd2; in_csr_num = 14'h006;
    in_rd_val = 32'h99; in_pc = 32'h1C00_0700;
    cyc(); idle_inputs();
    check("ertn_bus",   csr_bus, mk_bus(1'b1, 1'b0, 6'h00, 9'd0, 32'h0, 1'b0, 32'h0));
    check("ertn_flush", flush,   1'b1);
    check("ertn_wen",   csr_wen, 1'b0);
    check("ertn_rd_we", rd_we,   1'b0);
    cyc();
    check("ertn_in_flush_ready", in_ready, 1'b0);
    rst = 1'b1;
    cyc();
    check("mid_rst_bus",      csr_bus,   '0);
    check("mid_rst_wen",      csr_wen,   1'b0);
    check("mid_rst_waddr",    csr_waddr, 14'h0);
    check("mid_rst_wdata",    csr_wdata, 32'h0);
    check("mid_rst_rd_we",    rd_we,     1'b0);
    check("mid_rst_rd_wdata", rd_wdata,  32'h0);
    check("mid_rst_flush",    flush,     1'b0);
    check("mid_rst_ready",    in_ready,  1'b1);
    rst = 1'b0;
    cyc();
    check("post_rst_flush", flush,    1'b0);
    check("post_rst_wen",   csr_wen,  1'b0);
    check("post_rst_ready", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
